rv_skid_buffer: RTL and testbench

- Two-entry valid/ready skid buffer that sits directly upstream of a DEPTH=1 pipe-register stage.
- Converts a backpressured valid/ready stream into a fully registered output: data_out and valid_out come from flops, and ready_in is registered.
- Breaks the combinational ready path between pipeline stages without losing throughput: one transfer per cycle when ready_out is held high.
- Used in front of execute and commit pipe registers wherever the stall logic is timing-critical.

---
 rtl/rv_pipe_pkg.sv | 24 ++
 rtl/rv_skid_buffer_pipe_register.sv | 42 ++++
 rtl/rv_skid_buffer.sv | 127 ++++++++++++
 tb/tb_rv_skid_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared definitions for valid/ready pipe stages: state encoding and occupancy width.
package rv_pipe_pkg;

   localparam int COUNT_W = 2;

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   typedef enum logic [1:0] {
      S_EMPTY = EMPTY,
      S_ONE   = ONE,
      S_FULL  = FULL
   } skid_state_e;

   function automatic logic [COUNT_W-1:0] state_count(input skid_state_e st);
      case (st)
         S_ONE:   state_count = 2'd1;
         S_FULL:  state_count = 2'd2;
         default: state_count = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/rv_skid_buffer_pipe_register.sv
// Enabled pipe register of DEPTH stages; the low RESETW bits of every stage
// clear on synchronous active-low reset, the rest are plain data flops.
module RV_pipe_register #(
   parameter int DATAW  = 8,
   parameter int RESETW = 0,
   parameter int DEPTH  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [DATAW-1:0] data_in,
   output logic [DATAW-1:0] data_out
);

   localparam logic [DATAW-1:0] RST_MASK =
      (RESETW == 0) ? '0 : ({DATAW{1'b1}} >> (DATAW - RESETW));

   logic [DATAW-1:0] stage_q [DEPTH];
   logic [DATAW-1:0] stage_d [DEPTH];

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i];
         if (enable) begin
            stage_d[i] = (i == 0) ? data_in : stage_q[(i == 0) ? 0 : i - 1];
         end
         // Only the reset slice is cleared; with RESETW=0 the mask is empty.
         if (!reset) begin
            stage_d[i] = stage_d[i] & ~RST_MASK;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         stage_q[i] <= stage_d[i];
      end
   end

   assign data_out = stage_q[DEPTH-1];

endmodule

// File: rtl/rv_skid_buffer.sv
// Two-entry valid/ready skid buffer with fully registered valid_out, data_out and ready_in.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_EMPTY | nothing buffered, valid_out=0, ready_in=1
// S_ONE   | out_reg holds a payload, skid empty, ready_in=1
// S_FULL  | out_reg and skid_reg both hold payloads, ready_in=0
module rv_skid_buffer
   import rv_pipe_pkg::*;
#(
   parameter int DATAW = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               valid_in,
   output logic               ready_in,
   input  logic [DATAW-1:0]   data_in,
   output logic               valid_out,
   input  logic               ready_out,
   output logic [DATAW-1:0]   data_out,
   output logic [COUNT_W-1:0] count
);

   skid_state_e        state_q, state_d;
   logic               ready_in_q, ready_in_d;
   logic               valid_out_q, valid_out_d;
   logic [COUNT_W-1:0] count_q, count_d;

   logic               fire_in, fire_out;
   logic               load_out, load_skid, out_from_skid;
   logic [DATAW-1:0]   skid_data;
   logic [DATAW-1:0]   out_next;

   assign fire_in  = valid_in & ready_in_q;
   assign fire_out = valid_out_q & ready_out;

   always_comb begin
      state_d       = state_q;
      load_out      = 1'b0;
      load_skid     = 1'b0;
      out_from_skid = 1'b0;

      case (state_q)
         S_EMPTY: begin
            if (fire_in) begin
               load_out = 1'b1;
               state_d  = S_ONE;
            end
         end
         S_ONE: begin
            if (fire_in && fire_out) begin
               load_out = 1'b1;
            end else if (fire_in && !ready_out) begin
               load_skid = 1'b1;
               state_d   = S_FULL;
            end else if (!fire_in && fire_out) begin
               state_d = S_EMPTY;
            end
         end
         S_FULL: begin
            if (ready_out) begin
               load_out      = 1'b1;
               out_from_skid = 1'b1;
               state_d       = S_ONE;
            end
         end
         default: state_d = S_EMPTY;
      endcase

      // Flush completes any coincident handshake but drops the payload.
      if (flush) begin
         state_d   = S_EMPTY;
         load_out  = 1'b0;
         load_skid = 1'b0;
      end

      ready_in_d  = (state_d != S_FULL);
      valid_out_d = (state_d != S_EMPTY);
      count_d     = state_count(state_d);

      if (!reset) begin
         state_d     = S_EMPTY;
         ready_in_d  = 1'b0;
         valid_out_d = 1'b0;
         count_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      state_q     <= state_d;
      ready_in_q  <= ready_in_d;
      valid_out_q <= valid_out_d;
      count_q     <= count_d;
   end

   assign out_next = out_from_skid ? skid_data : data_in;

   RV_pipe_register #(
      .DATAW  (DATAW),
      .RESETW (0),
      .DEPTH  (1)
   ) u_out_reg (
      .clk      (clk),
      .reset    (1'b1),
      .enable   (load_out),
      .data_in  (out_next),
      .data_out (data_out)
   );

   RV_pipe_register #(
      .DATAW  (DATAW),
      .RESETW (0),
      .DEPTH  (1)
   ) u_skid_reg (
      .clk      (clk),
      .reset    (1'b1),
      .enable   (load_skid),
      .data_in  (data_in),
      .data_out (skid_data)
   );

   assign ready_in  = ready_in_q;
   assign valid_out = valid_out_q;
   assign count     = count_q;

endmodule

// File: tb/tb_rv_skid_buffer.sv
// Directed bench for rv_skid_buffer: reset, streaming, backpressure, flush and mid-stream reset.
module tb_rv_skid_buffer;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic       valid_in;
   logic       ready_in;
   logic [7:0] data_in;
   logic       valid_out;
   logic       ready_out;
   logic [7:0] data_out;
   logic [1:0] count;

   int n_pass  = 0;
   int n_total = 0;

   rv_skid_buffer #(.DATAW(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .data_in   (data_in),
      .valid_out (valid_out),
      .ready_out (ready_out),
      .data_out  (data_out),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_out = 1'b0; data_in = 8'h00;
      for (int i = 0; i < 3; i++) begin
         step();
         n_total++;
         if (ready_in !== 1'b0) $display("FAIL reset_ready_in cyc%0d got %b want 0", i, ready_in);
         else n_pass++;
         n_total++;
         if (valid_out !== 1'b0) $display("FAIL reset_valid_out cyc%0d got %b want 0", i, valid_out);
         else n_pass++;
      end
      reset = 1'b1;
      step();
      n_total++;
      if (ready_in !== 1'b1) $display("FAIL release_ready_in got %b want 1", ready_in);
      else n_pass++;
      n_total++;
      if (count !== 2'd0) $display("FAIL release_count got %0d want 0", count);
      else n_pass++;
      n_total++;
      if (valid_out !== 1'b0) $display("FAIL release_valid_out got %b want 0", valid_out);
      else n_pass++;
   endtask

   task automatic test_streaming();
      logic [7:0] pay [3];
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
      ready_out = 1'b1;
      for (int i = 0; i < 3; i++) begin
         valid_in = 1'b1; data_in = pay[i];
         step();
         n_total++;
         if (valid_out !== 1'b1 || data_out !== pay[i])
            $display("FAIL stream_data%0d got v=%b d=%h want v=1 d=%h", i, valid_out, data_out, pay[i]);
         else n_pass++;
         n_total++;
         if (count !== 2'd1 || ready_in !== 1'b1)
            $display("FAIL stream_occ%0d got cnt=%0d rdy=%b want cnt=1 rdy=1", i, count, ready_in);
         else n_pass++;
      end
      valid_in = 1'b0;
      step();
      n_total++;
      if (valid_out !== 1'b0 || count !== 2'd0)
         $display("FAIL stream_drain got v=%b cnt=%0d want v=0 cnt=0", valid_out, count);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      ready_out = 1'b0;
      valid_in = 1'b1; data_in = 8'h44;
      step();
      n_total++;
      if (count !== 2'd1 || data_out !== 8'h44 || ready_in !== 1'b1)
         $display("FAIL bp_first got cnt=%0d d=%h rdy=%b want cnt=1 d=44 rdy=1", count, data_out, ready_in);
      else n_pass++;
      data_in = 8'h55;
      step();
      n_total++;
      if (count !== 2'd2 || ready_in !== 1'b0 || data_out !== 8'h44 || valid_out !== 1'b1)
         $display("FAIL bp_full got cnt=%0d rdy=%b d=%h v=%b want cnt=2 rdy=0 d=44 v=1",
                  count, ready_in, data_out, valid_out);
      else n_pass++;
      valid_in = 1'b0; data_in = 8'hEE;
      step();
      n_total++;
      if (count !== 2'd2 || data_out !== 8'h44 || valid_out !== 1'b1)
         $display("FAIL bp_hold got cnt=%0d d=%h v=%b want cnt=2 d=44 v=1", count, data_out, valid_out);
      else n_pass++;
      ready_out = 1'b1;
      step();
      n_total++;
      if (count !== 2'd1 || data_out !== 8'h55 || valid_out !== 1'b1 || ready_in !== 1'b1)
         $display("FAIL bp_drain1 got cnt=%0d d=%h v=%b rdy=%b want cnt=1 d=55 v=1 rdy=1",
                  count, data_out, valid_out, ready_in);
      else n_pass++;
      step();
      n_total++;
      if (count !== 2'd0 || valid_out !== 1'b0)
         $display("FAIL bp_drain2 got cnt=%0d v=%b want cnt=0 v=0", count, valid_out);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      ready_out = 1'b0; valid_in = 1'b1; data_in = 8'h66;
      step();
      n_total++;
      if (count !== 2'd1 || data_out !== 8'h66)
         $display("FAIL sim_load got cnt=%0d d=%h want cnt=1 d=66", count, data_out);
      else n_pass++;
      ready_out = 1'b1; data_in = 8'h77;
      step();
      n_total++;
      if (count !== 2'd1 || data_out !== 8'h77 || valid_out !== 1'b1 || ready_in !== 1'b1)
         $display("FAIL sim_swap got cnt=%0d d=%h v=%b rdy=%b want cnt=1 d=77 v=1 rdy=1",
                  count, data_out, valid_out, ready_in);
      else n_pass++;
      valid_in = 1'b0;
      step();
      n_total++;
      if (count !== 2'd0 || valid_out !== 1'b0)
         $display("FAIL sim_drain got cnt=%0d v=%b want cnt=0 v=0", count, valid_out);
      else n_pass++;
   endtask

   task automatic test_flush_full();
      ready_out = 1'b0; valid_in = 1'b1; data_in = 8'h88;
      step();
      data_in = 8'h99;
      step();
      n_total++;
      if (count !== 2'd2 || data_out !== 8'h88)
         $display("FAIL flush_fill got cnt=%0d d=%h want cnt=2 d=88", count, data_out);
      else n_pass++;
      valid_in = 1'b0; flush = 1'b1; ready_out = 1'b1;
      step();
      flush = 1'b0;
      n_total++;
      if (valid_out !== 1'b0 || count !== 2'd0 || ready_in !== 1'b1)
         $display("FAIL flush_full got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1", valid_out, count, ready_in);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         step();
         n_total++;
         if (valid_out !== 1'b0 || count !== 2'd0)
            $display("FAIL flush_no99_%0d got v=%b d=%h want v=0", i, valid_out, data_out);
         else n_pass++;
      end
   endtask

   task automatic test_flush_fire();
      ready_out = 1'b0; valid_in = 1'b1; data_in = 8'h12;
      step();
      flush = 1'b1; data_in = 8'h34;
      step();
      flush = 1'b0; valid_in = 1'b0;
      n_total++;
      if (valid_out !== 1'b0 || count !== 2'd0 || ready_in !== 1'b1)
         $display("FAIL flush_fire got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1", valid_out, count, ready_in);
      else n_pass++;
      step();
      n_total++;
      if (valid_out !== 1'b0)
         $display("FAIL flush_fire_drop got v=%b d=%h want v=0", valid_out, data_out);
      else n_pass++;
   endtask

   task automatic test_reset_midstream();
      ready_out = 1'b0; valid_in = 1'b1; data_in = 8'hAA;
      step();
      data_in = 8'hBB;
      step();
      n_total++;
      if (count !== 2'd2)
         $display("FAIL rst_mid_fill got cnt=%0d want 2", count);
      else n_pass++;
      reset = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
      step();
      n_total++;
      if (valid_out !== 1'b0 || ready_in !== 1'b0 || count !== 2'd0)
         $display("FAIL rst_mid got v=%b rdy=%b cnt=%0d want v=0 rdy=0 cnt=0", valid_out, ready_in, count);
      else n_pass++;
      reset = 1'b1;
      step();
      n_total++;
      if (valid_out !== 1'b0 || ready_in !== 1'b1)
         $display("FAIL rst_mid_release got v=%b rdy=%b want v=0 rdy=1", valid_out, ready_in);
      else n_pass++;
      valid_in = 1'b1; data_in = 8'hCC;
      step();
      valid_in = 1'b0;
      n_total++;
      if (valid_out !== 1'b1 || data_out !== 8'hCC || count !== 2'd1)
         $display("FAIL rst_mid_first got v=%b d=%h cnt=%0d want v=1 d=cc cnt=1", valid_out, data_out, count);
      else n_pass++;
      step();
      n_total++;
      if (valid_out !== 1'b0 || count !== 2'd0)
         $display("FAIL rst_mid_drain got v=%b cnt=%0d want v=0 cnt=0", valid_out, count);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_simultaneous();
      test_flush_full();
      test_flush_fire();
      test_reset_midstream();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
